// File: rtl/stack_bist_ctrl.sv
// stack_bist_ctrl: fill/overflow/drain/underflow self-test initiator for a LIFO stack
module stack_bist_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] SEED = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [3:0]            err_flags,
  output logic [ADDR_WIDTH-1:0] first_err_idx,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  full,
  output logic                  pop,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  empty
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int EW = ADDR_WIDTH + 2;
  typedef enum logic [3:0] {IDLE, FILL, CHK_FULL, OVF, DRAIN, LAST, CHK_EMPTY, UNF, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH:0] idx, idx_n;
  logic [ADDR_WIDTH-1:0] exp_idx;
  logic chk, accept, last_step, mism;
  logic [3:0] e, flags_n;
  logic [2:0] inc;
  logic [EW-1:0] base, cnt_n;
  logic [EW:0] sum;
  always_comb begin
    accept = start && (state == IDLE || state == DONE);
    last_step = idx == (ADDR_WIDTH+1)'(DEPTH - 1);
    state_n = state;
    case (state)
      IDLE, DONE: state_n = accept ? FILL : state;
      FILL:       state_n = last_step ? CHK_FULL : FILL;
      CHK_FULL:   state_n = OVF;
      OVF:        state_n = DRAIN;
      DRAIN:      state_n = last_step ? LAST : DRAIN;
      LAST:       state_n = CHK_EMPTY;
      CHK_EMPTY:  state_n = UNF;
      UNF:        state_n = DONE;
      default:    state_n = IDLE;
    endcase
    idx_n = (state_n != state) ? '0 : idx + 1'b1;
    // rd_data lags its pop by one cycle, so compare against the index registered last cycle
    mism = chk && (rd_data != SEED + DATA_WIDTH'(exp_idx));
    e[0] = accept && !empty;
    e[1] = (state == CHK_FULL || (state == DRAIN && idx == '0)) && !full;
    e[2] = state == CHK_EMPTY && !empty;
    e[3] = mism;
    inc = 3'(e[0]) + 3'(e[1]) + 3'(e[2]) + 3'(e[3]);
    base = accept ? '0 : err_count;
    sum = {1'b0, base} + (EW+1)'(inc);
    cnt_n = sum[EW] ? '1 : sum[EW-1:0];
    flags_n = (accept ? 4'b0 : err_flags) | e;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      exp_idx <= '0;
      chk <= 1'b0;
      err_count <= '0;
      err_flags <= '0;
      first_err_idx <= '0;
      push <= 1'b0;
      pop <= 1'b0;
      wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      chk <= state == DRAIN;
      exp_idx <= ADDR_WIDTH'(DEPTH - 1) - idx[ADDR_WIDTH-1:0];
      err_count <= cnt_n;
      err_flags <= flags_n;
      first_err_idx <= accept ? '0 : (mism && !err_flags[3]) ? exp_idx : first_err_idx;
      push <= state_n == FILL || state_n == OVF;
      pop <= state_n == DRAIN || state_n == UNF;
      wr_data <= state_n == OVF ? ~SEED : state_n == FILL ? SEED + DATA_WIDTH'(idx_n) : '0;
      busy <= !(state_n == IDLE || state_n == DONE);
      done <= state_n == DONE;
      pass <= state_n == DONE && cnt_n == '0;
    end
  end
endmodule

// File: tb/tb_stack_bist_ctrl.sv
// tb_stack_bist_ctrl: BIST controller against a behavioural stack with injectable faults
module tb_stack_bist_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, pass, push, pop, full, empty;
  logic [5:0] err_count;
  logic [3:0] err_flags, first_err_idx;
  logic [31:0] wr_data, rd_data;
  logic [31:0] mem [16];
  logic [4:0] sp;
  int fault = 0;
  int checks = 0, errors = 0;
  typedef struct {int cnt; int flags; int fidx; int pass;} res_t;
  logic [31:0] wq [$];
  res_t rq [$];

  stack_bist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .err_flags(err_flags), .first_err_idx(first_err_idx),
    .push(push), .wr_data(wr_data), .full(full), .pop(pop), .rd_data(rd_data), .empty(empty)
  );

  always #5 clk = ~clk;

  // fault 1 flips bit 0 of the third word returned from a full stack; 2/3 tie full/empty low
  assign full = (fault == 2) ? 1'b0 : sp == 5'd16;
  assign empty = (fault == 3) ? 1'b0 : sp == 5'd0;
  always @(posedge clk) begin
    if (rst) begin
      sp <= '0;
      rd_data <= '0;
    end else if (push && sp != 5'd16) begin
      mem[sp[3:0]] <= wr_data;
      sp <= sp + 5'd1;
    end else if (pop && sp != 5'd0) begin
      rd_data <= mem[4'(sp - 5'd1)] ^ {31'b0, fault == 1 && sp == 5'd14};
      sp <= sp - 5'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && push) begin
      if (wq.size() == 0) check("push_extra", 1, 0);
      else check("wr_data", wr_data, wq.pop_front());
    end
  end

  function automatic res_t exp_of(input int f);
    res_t r;
    r = '{0, 0, 0, 1};
    if (f == 1) r = '{1, 8, 13, 0};
    if (f == 2) r = '{2, 2, 0, 0};
    if (f == 3) r = '{2, 5, 0, 0};
    return r;
  endfunction

  task automatic run(input int f, input bit ign, input bit abrt);
    int n;
    res_t r;
    fault = f;
    for (int i = 0; i < 16; i++) wq.push_back(i);
    wq.push_back(32'hFFFF_FFFF);
    if (!abrt) rq.push_back(exp_of(f));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_on", busy, 1);
    check("done_clr", done, 0);
    n = 1;
    while (!done && n < 100) begin
      if (ign && n == 10) start = 1'b1;
      if (abrt && n == 5) rst = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      n++;
      if (abrt && n == 6) begin
        check("abort_out", {push, busy, done}, 3'b000);
        rst = 1'b0;
        wq.delete();
        return;
      end
    end
    check("done_cycle", n, 38);
    check("busy_off", busy, 0);
    check("wq_empty", wq.size(), 0);
    if (rq.size() == 0) check("rq_empty", 1, 0);
    else begin
      r = rq.pop_front();
      check("err_count", err_count, r.cnt);
      check("err_flags", err_flags, r.flags);
      check("first_err_idx", first_err_idx, r.fidx);
      check("pass", pass, r.pass);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("reset_out", {busy, done, pass, push, pop, err_count, err_flags, first_err_idx, wr_data}, 0);
    end
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    run(0, 0, 0);
    run(1, 0, 0);
    run(2, 0, 0);
    run(3, 0, 0);
    run(0, 0, 1);
    run(0, 0, 0);
    run(0, 1, 0);
    run(0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
